mac_hdr_extractor: RTL and testbench
====================================

# mac_hdr_extractor

Parametrised successor to the single-address RX header decode inside the xpu. It consumes the PHY RX byte stream (`pkt_header_valid_strobe`, `byte_in_strobe`/`byte_in`/`byte_count`, `fcs_in_strobe`/`fcs_ok`) and captures FC+duration, addr1..addr3 and sequence control. It matches addr1 against up to NUM_OWN_MAC programmable station addresses, plus broadcast and multicast. It checks byte-index continuity and reports per-packet completion with the FCS result for the downstream filter and ACK logic.

## Interface
- NUM_OWN_MAC, 4, number of own-address slots (1..2^MATCH_IDX_WIDTH)
- MATCH_IDX_WIDTH, 2, width of `match_idx`
- `s00_axi_aclk`  in  1  sole clock
- `s00_axi_aresetn`  in  1  reset; asynchronous, active-low
- `pkt_header_valid_strobe`  in  1  start of new PSDU
- `byte_in_strobe`  in  1  `byte_in` valid
- `byte_in`  in  8  PSDU byte
- `byte_count`  in  16  index of `byte_in` within PSDU, 0-based
- `fcs_in_strobe`  in  1  end of PSDU
- `fcs_ok`  in  1  FCS result, sampled with `fcs_in_strobe`
- `own_mac`  in  48*NUM_OWN_MAC  slot k at bits [48k+47:48k], same byte order as `addr1`
- `own_mac_en`  in  NUM_OWN_MAC  per-slot enable
- `bcast_accept`  in  1  broadcast addr1 counts as for-me
- `FC_DI`  out  32  {byte3,byte2,byte1,byte0}
- `FC_DI_valid`  out  1  level
- `addr1`/`addr2`/`addr3`  out  48 each  {byte(n+5)..byte(n)}, n = 4/10/16
- `addr1_valid`/`addr2_valid`/`addr3_valid`  out  1 each  level
- `seq_ctrl`  out  16  {byte23,byte22}
- `seq_ctrl_valid`  out  1  level
- `pkt_for_me`  out  1  addr1 hit, level
- `match_idx`  out  MATCH_IDX_WIDTH  lowest matching enabled slot
- `is_bcast`, `is_mcast`  out  1 each  addr1 all-ones / addr1 bit0
- `hdr_err`  out  1  byte-index discontinuity, level
- `pkt_done`  out  1  one-cycle pulse at end of PSDU
- `fcs_ok_lock`  out  1  `fcs_ok` latched on `fcs_in_strobe`

## Operation
- FSM states: IDLE, HDR, PAYLOAD, ERR, DONE.
- Any state + `pkt_header_valid_strobe` -> HDR.
  - Clears all valids, `pkt_for_me`, `match_idx`, `is_bcast`, `is_mcast`, `hdr_err`, `fcs_ok_lock`.
  - Sets expected index to 0.
  - Data registers keep their old values.
- HDR, byte strobe with `byte_count` == expected:
  - Shift `byte_in` into the field selected by position (0-3 FC_DI, 4-9 addr1, 10-15 addr2, 16-21 addr3, 22-23 seq_ctrl).
  - Increment expected index.
- Field valid rises after the field's last byte (index 3/9/15/21/23).
- Index 23 accepted -> PAYLOAD.
- HDR, byte strobe with `byte_count` != expected -> ERR, `hdr_err`=1. Fields not yet complete stay invalid.
- PAYLOAD and ERR ignore byte contents.
- IDLE and DONE ignore bytes.
- HDR/PAYLOAD/ERR + `fcs_in_strobe` -> DONE: `pkt_done` pulse, `fcs_ok_lock`=`fcs_ok`. In IDLE/DONE, `fcs_in_strobe` is ignored.
- Short frames (ACK/CTS, 14 B): FCS arrives in HDR, and only the completed fields are valid.
- Match is evaluated on the index-9 byte using {byte_in, captured bytes 4-8}.
  - `own_mac`/`own_mac_en` are sampled only on that cycle; later changes do not affect the current packet.
  - `match_idx` is the lowest enabled slot equal to addr1, else 0.
  - `pkt_for_me` = any enabled hit | (`is_bcast` & `bcast_accept`).
  - `is_mcast` = addr1[0]. Broadcast is also multicast.
- Simultaneous events:
  - Header + byte: header wins, byte dropped.
  - Header + fcs: header wins.
  - Byte + fcs: byte processed, then DONE.
- Reset (any time, asynchronous): state IDLE; every output 0, including data registers; expected index 0.

## Timing
- Registered outputs, 1-cycle latency: a field valid, `pkt_for_me`, `match_idx`, `is_bcast` and `is_mcast` assert on the edge after the closing byte's strobe edge.
- `hdr_err` asserts 1 cycle after the offending strobe.
- `pkt_done` and `fcs_ok_lock` update 1 cycle after `fcs_in_strobe`. `pkt_done` is high for exactly 1 cycle.
- Valids and `fcs_ok_lock` hold until the next header strobe or reset.
- Back-to-back bytes are accepted every cycle; gaps of any length are tolerated.
- `byte_count` is compared at its full 16 bits; no wrap handling is needed past 23.

## Test plan
- Slot 0 = 48'hFFEEDDCCBBAA, enabled. Send a 64-byte data frame with header 08 01 00 00 AA BB CC DD EE FF 11 22 33 44 55 66 77 88 99 AA BB CC 00 00, then `fcs_ok`=1. Required:
  - FC_DI=32'h00000108
  - addr1=48'hFFEEDDCCBBAA, addr2=48'h665544332211, addr3=48'hCCBBAA998877
  - `pkt_for_me`=1, `match_idx`=0
  - `pkt_done` one cycle, `fcs_ok_lock`=1
- Same frame with slot 0 disabled and slot 2 = the same address, enabled: `pkt_for_me`=1, `match_idx`=2. With all slots disabled: `pkt_for_me`=0.
- addr1 = FF×6:
  - `bcast_accept`=1 -> `is_bcast`=`is_mcast`=`pkt_for_me`=1.
  - `bcast_accept`=0 -> `pkt_for_me`=0.
  - addr1 starting 01:00:5E -> `is_mcast`=1, `is_bcast`=0.
- 14-byte ACK, `fcs_ok`=0: FC_DI_valid=addr1_valid=1; addr2/addr3/seq valids=0; `fcs_ok_lock`=0.
- `byte_count` jumps 6 -> 8:
  - `hdr_err`=1, addr1_valid stays 0.
  - Next header strobe clears `hdr_err`, and a clean frame decodes correctly.
- Deassert `s00_axi_aresetn` after byte 12 of a frame: all outputs 0 immediately. After release, bytes without a header strobe are ignored; a following full frame decodes correctly.

Source files
------------

// File: rtl/mac_hdr_extractor.sv
// mac_hdr_extractor: captures the 802.11 MAC header from the PHY RX byte
// stream and matches addr1 against programmable station addresses.
module mac_hdr_extractor #(
    parameter int NUM_OWN_MAC     = 4,
    parameter int MATCH_IDX_WIDTH = 2
) (
    input  logic                         s00_axi_aclk,
    input  logic                         s00_axi_aresetn,
    input  logic                         pkt_header_valid_strobe,
    input  logic                         byte_in_strobe,
    input  logic [7:0]                   byte_in,
    input  logic [15:0]                  byte_count,
    input  logic                         fcs_in_strobe,
    input  logic                         fcs_ok,
    input  logic [48*NUM_OWN_MAC-1:0]    own_mac,
    input  logic [NUM_OWN_MAC-1:0]       own_mac_en,
    input  logic                         bcast_accept,
    output logic [31:0]                  FC_DI,
    output logic                         FC_DI_valid,
    output logic [47:0]                  addr1,
    output logic                         addr1_valid,
    output logic [47:0]                  addr2,
    output logic                         addr2_valid,
    output logic [47:0]                  addr3,
    output logic                         addr3_valid,
    output logic [15:0]                  seq_ctrl,
    output logic                         seq_ctrl_valid,
    output logic                         pkt_for_me,
    output logic [MATCH_IDX_WIDTH-1:0]   match_idx,
    output logic                         is_bcast,
    output logic                         is_mcast,
    output logic                         hdr_err,
    output logic                         pkt_done,
    output logic                         fcs_ok_lock
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_ERR,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [4:0]                 exp_idx_q, exp_idx_d;
    logic [31:0]                fc_di_q, fc_di_d;
    logic [47:0]                addr1_q, addr1_d;
    logic [47:0]                addr2_q, addr2_d;
    logic [47:0]                addr3_q, addr3_d;
    logic [15:0]                seq_ctrl_q, seq_ctrl_d;
    logic                       fc_di_valid_q, fc_di_valid_d;
    logic                       addr1_valid_q, addr1_valid_d;
    logic                       addr2_valid_q, addr2_valid_d;
    logic                       addr3_valid_q, addr3_valid_d;
    logic                       seq_ctrl_valid_q, seq_ctrl_valid_d;
    logic                       pkt_for_me_q, pkt_for_me_d;
    logic [MATCH_IDX_WIDTH-1:0] match_idx_q, match_idx_d;
    logic                       is_bcast_q, is_bcast_d;
    logic                       is_mcast_q, is_mcast_d;
    logic                       hdr_err_q, hdr_err_d;
    logic                       pkt_done_q, pkt_done_d;
    logic                       fcs_ok_lock_q, fcs_ok_lock_d;

    logic                       idx_ok;
    logic                       byte_acc;
    logic                       in_pkt;
    logic [47:0]                addr1_new;
    logic                       own_hit;
    logic [MATCH_IDX_WIDTH-1:0] own_idx;
    logic                       new_bcast;

    assign idx_ok   = (byte_count == {11'd0, exp_idx_q});
    assign byte_acc = (state_q == S_HDR) && byte_in_strobe;
    assign in_pkt   = (state_q == S_HDR) || (state_q == S_PAYLOAD) ||
                      (state_q == S_ERR);

    // addr1 as it will look once the index-9 byte is shifted in
    assign addr1_new = {byte_in, addr1_q[47:8]};
    assign new_bcast = &addr1_new;

    // Descending scan so the lowest matching slot is the last write
    always_comb begin
        own_hit = 1'b0;
        own_idx = '0;
        for (int k = NUM_OWN_MAC - 1; k >= 0; k--) begin
            if (own_mac_en[k] && (own_mac[48*k +: 48] == addr1_new)) begin
                own_hit = 1'b1;
                own_idx = MATCH_IDX_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (pkt_header_valid_strobe) begin
            state_d = S_HDR;
        end else begin
            unique case (state_q)
                S_HDR: begin
                    if (byte_in_strobe && !idx_ok) begin
                        state_d = S_ERR;
                    end else if (byte_in_strobe && (exp_idx_q == 5'd23)) begin
                        state_d = S_PAYLOAD;
                    end
                    if (fcs_in_strobe) begin
                        state_d = S_DONE;
                    end
                end
                S_PAYLOAD, S_ERR: begin
                    if (fcs_in_strobe) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        exp_idx_d        = exp_idx_q;
        fc_di_d          = fc_di_q;
        addr1_d          = addr1_q;
        addr2_d          = addr2_q;
        addr3_d          = addr3_q;
        seq_ctrl_d       = seq_ctrl_q;
        fc_di_valid_d    = fc_di_valid_q;
        addr1_valid_d    = addr1_valid_q;
        addr2_valid_d    = addr2_valid_q;
        addr3_valid_d    = addr3_valid_q;
        seq_ctrl_valid_d = seq_ctrl_valid_q;
        pkt_for_me_d     = pkt_for_me_q;
        match_idx_d      = match_idx_q;
        is_bcast_d       = is_bcast_q;
        is_mcast_d       = is_mcast_q;
        hdr_err_d        = hdr_err_q;
        pkt_done_d       = 1'b0;
        fcs_ok_lock_d    = fcs_ok_lock_q;

        if (pkt_header_valid_strobe) begin
            exp_idx_d        = '0;
            fc_di_valid_d    = 1'b0;
            addr1_valid_d    = 1'b0;
            addr2_valid_d    = 1'b0;
            addr3_valid_d    = 1'b0;
            seq_ctrl_valid_d = 1'b0;
            pkt_for_me_d     = 1'b0;
            match_idx_d      = '0;
            is_bcast_d       = 1'b0;
            is_mcast_d       = 1'b0;
            hdr_err_d        = 1'b0;
            fcs_ok_lock_d    = 1'b0;
        end else begin
            if (byte_acc && idx_ok) begin
                exp_idx_d = exp_idx_q + 5'd1;
                unique case (1'b1)
                    (exp_idx_q inside {[5'd0:5'd3]}): begin
                        fc_di_d = {byte_in, fc_di_q[31:8]};
                        if (exp_idx_q == 5'd3) begin
                            fc_di_valid_d = 1'b1;
                        end
                    end
                    (exp_idx_q inside {[5'd4:5'd9]}): begin
                        addr1_d = addr1_new;
                        if (exp_idx_q == 5'd9) begin
                            addr1_valid_d = 1'b1;
                            match_idx_d   = own_idx;
                            is_bcast_d    = new_bcast;
                            is_mcast_d    = addr1_new[0];
                            pkt_for_me_d  = own_hit |
                                            (new_bcast & bcast_accept);
                        end
                    end
                    (exp_idx_q inside {[5'd10:5'd15]}): begin
                        addr2_d = {byte_in, addr2_q[47:8]};
                        if (exp_idx_q == 5'd15) begin
                            addr2_valid_d = 1'b1;
                        end
                    end
                    (exp_idx_q inside {[5'd16:5'd21]}): begin
                        addr3_d = {byte_in, addr3_q[47:8]};
                        if (exp_idx_q == 5'd21) begin
                            addr3_valid_d = 1'b1;
                        end
                    end
                    default: begin
                        seq_ctrl_d = {byte_in, seq_ctrl_q[15:8]};
                        if (exp_idx_q == 5'd23) begin
                            seq_ctrl_valid_d = 1'b1;
                        end
                    end
                endcase
            end else if (byte_acc) begin
                hdr_err_d = 1'b1;
            end

            if (fcs_in_strobe && in_pkt) begin
                pkt_done_d    = 1'b1;
                fcs_ok_lock_d = fcs_ok;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            exp_idx_q        <= '0;
            fc_di_q          <= '0;
            addr1_q          <= '0;
            addr2_q          <= '0;
            addr3_q          <= '0;
            seq_ctrl_q       <= '0;
            fc_di_valid_q    <= 1'b0;
            addr1_valid_q    <= 1'b0;
            addr2_valid_q    <= 1'b0;
            addr3_valid_q    <= 1'b0;
            seq_ctrl_valid_q <= 1'b0;
            pkt_for_me_q     <= 1'b0;
            match_idx_q      <= '0;
            is_bcast_q       <= 1'b0;
            is_mcast_q       <= 1'b0;
            hdr_err_q        <= 1'b0;
            pkt_done_q       <= 1'b0;
            fcs_ok_lock_q    <= 1'b0;
        end else begin
            exp_idx_q        <= exp_idx_d;
            fc_di_q          <= fc_di_d;
            addr1_q          <= addr1_d;
            addr2_q          <= addr2_d;
            addr3_q          <= addr3_d;
            seq_ctrl_q       <= seq_ctrl_d;
            fc_di_valid_q    <= fc_di_valid_d;
            addr1_valid_q    <= addr1_valid_d;
            addr2_valid_q    <= addr2_valid_d;
            addr3_valid_q    <= addr3_valid_d;
            seq_ctrl_valid_q <= seq_ctrl_valid_d;
            pkt_for_me_q     <= pkt_for_me_d;
            match_idx_q      <= match_idx_d;
            is_bcast_q       <= is_bcast_d;
            is_mcast_q       <= is_mcast_d;
            hdr_err_q        <= hdr_err_d;
            pkt_done_q       <= pkt_done_d;
            fcs_ok_lock_q    <= fcs_ok_lock_d;
        end
    end

    assign FC_DI          = fc_di_q;
    assign FC_DI_valid    = fc_di_valid_q;
    assign addr1          = addr1_q;
    assign addr1_valid    = addr1_valid_q;
    assign addr2          = addr2_q;
    assign addr2_valid    = addr2_valid_q;
    assign addr3          = addr3_q;
    assign addr3_valid    = addr3_valid_q;
    assign seq_ctrl       = seq_ctrl_q;
    assign seq_ctrl_valid = seq_ctrl_valid_q;
    assign pkt_for_me     = pkt_for_me_q;
    assign match_idx      = match_idx_q;
    assign is_bcast       = is_bcast_q;
    assign is_mcast       = is_mcast_q;
    assign hdr_err        = hdr_err_q;
    assign pkt_done       = pkt_done_q;
    assign fcs_ok_lock    = fcs_ok_lock_q;

endmodule

// File: tb/tb_mac_hdr_extractor.sv
// tb_mac_hdr_extractor: directed and randomized frames checked against a
// byte-array reference model of the header layout and addr1 matching.
module tb_mac_hdr_extractor;

    localparam int N = 4;
    localparam int W = 2;

    logic            s00_axi_aclk = 1'b0;
    logic            s00_axi_aresetn;
    logic            pkt_header_valid_strobe;
    logic            byte_in_strobe;
    logic [7:0]      byte_in;
    logic [15:0]     byte_count;
    logic            fcs_in_strobe;
    logic            fcs_ok;
    logic [48*N-1:0] own_mac;
    logic [N-1:0]    own_mac_en;
    logic            bcast_accept;
    logic [31:0]     FC_DI;
    logic            FC_DI_valid;
    logic [47:0]     addr1, addr2, addr3;
    logic            addr1_valid, addr2_valid, addr3_valid;
    logic [15:0]     seq_ctrl;
    logic            seq_ctrl_valid;
    logic            pkt_for_me;
    logic [W-1:0]    match_idx;
    logic            is_bcast, is_mcast;
    logic            hdr_err;
    logic            pkt_done;
    logic            fcs_ok_lock;

    mac_hdr_extractor #(.NUM_OWN_MAC(N), .MATCH_IDX_WIDTH(W)) dut (
        .s00_axi_aclk            (s00_axi_aclk),
        .s00_axi_aresetn         (s00_axi_aresetn),
        .pkt_header_valid_strobe (pkt_header_valid_strobe),
        .byte_in_strobe          (byte_in_strobe),
        .byte_in                 (byte_in),
        .byte_count              (byte_count),
        .fcs_in_strobe           (fcs_in_strobe),
        .fcs_ok                  (fcs_ok),
        .own_mac                 (own_mac),
        .own_mac_en              (own_mac_en),
        .bcast_accept            (bcast_accept),
        .FC_DI                   (FC_DI),
        .FC_DI_valid             (FC_DI_valid),
        .addr1                   (addr1),
        .addr1_valid             (addr1_valid),
        .addr2                   (addr2),
        .addr2_valid             (addr2_valid),
        .addr3                   (addr3),
        .addr3_valid             (addr3_valid),
        .seq_ctrl                (seq_ctrl),
        .seq_ctrl_valid          (seq_ctrl_valid),
        .pkt_for_me              (pkt_for_me),
        .match_idx               (match_idx),
        .is_bcast                (is_bcast),
        .is_mcast                (is_mcast),
        .hdr_err                 (hdr_err),
        .pkt_done                (pkt_done),
        .fcs_ok_lock             (fcs_ok_lock)
    );

    always #5 s00_axi_aclk = ~s00_axi_aclk;

    int checks = 0;
    int errors = 0;

    logic [7:0]      fb [0:63];
    logic [48*N-1:0] snap_mac;
    logic [N-1:0]    snap_en;
    logic            snap_bc;

    task automatic tick();
        @(posedge s00_axi_aclk);
        #1;
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [47:0] obs,
                        input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_std();
        logic [191:0] s;
        s = 192'h08010000_AABBCCDDEEFF_112233445566_778899AABBCC_0000;
        for (int i = 0; i < 24; i++) fb[i] = s[191-8*i -: 8];
        for (int i = 24; i < 64; i++) fb[i] = 8'(i);
    endtask

    task automatic hdr_strobe();
        pkt_header_valid_strobe = 1'b1;
        tick();
        pkt_header_valid_strobe = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idx);
        byte_in_strobe = 1'b1;
        byte_in        = b;
        byte_count     = 16'(idx);
        tick();
        byte_in_strobe = 1'b0;
    endtask

    task automatic send_fcs(input logic ok);
        fcs_in_strobe = 1'b1;
        fcs_ok        = ok;
        tick();
        fcs_in_strobe = 1'b0;
        chkb("pkt_done_pulse", pkt_done, 1'b1);
        tick();
        chkb("pkt_done_single", pkt_done, 1'b0);
    endtask

    task automatic send_frame(input int len, input logic ok,
                              input bit gaps, input bit scr);
        logic [63:0] t;
        hdr_strobe();
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(3) == 0) tick();
            if (i == 9) begin
                snap_mac = own_mac;
                snap_en  = own_mac_en;
                snap_bc  = bcast_accept;
            end
            send_byte(fb[i], i);
            if (i == 9 && scr) begin
                for (int k = 0; k < N; k++) begin
                    t = {$urandom(), $urandom()};
                    own_mac[48*k +: 48] = t[47:0];
                end
                t = {$urandom(), $urandom()};
                own_mac_en = t[N-1:0];
            end
        end
        send_fcs(ok);
    endtask

    // Reference: fields are byte slices of the frame, match is a slot scan
    task automatic exp_frame(input int len, input logic ok);
        logic [47:0] a1;
        logic        hit, bc, pfm;
        int          idx;
        a1 = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4]};
        chkb("fc_valid", FC_DI_valid, len >= 4);
        chkb("a1_valid", addr1_valid, len >= 10);
        chkb("a2_valid", addr2_valid, len >= 16);
        chkb("a3_valid", addr3_valid, len >= 22);
        chkb("seq_valid", seq_ctrl_valid, len >= 24);
        if (len >= 4)
            chkw("fc", 48'(FC_DI), 48'({fb[3], fb[2], fb[1], fb[0]}));
        if (len >= 10) chkw("a1", addr1, a1);
        if (len >= 16)
            chkw("a2", addr2, {fb[15], fb[14], fb[13], fb[12], fb[11], fb[10]});
        if (len >= 22)
            chkw("a3", addr3, {fb[21], fb[20], fb[19], fb[18], fb[17], fb[16]});
        if (len >= 24) chkw("seq", 48'(seq_ctrl), 48'({fb[23], fb[22]}));
        hit = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            if (!hit && snap_en[k] && snap_mac[48*k +: 48] == a1) begin
                hit = 1'b1;
                idx = k;
            end
        end
        bc  = (a1 == 48'hFFFF_FFFF_FFFF);
        pfm = hit || (bc && snap_bc);
        if (len < 10) begin
            pfm = 1'b0;
            idx = 0;
            bc  = 1'b0;
        end
        chkb("for_me", pkt_for_me, pfm);
        chkw("match_idx", 48'(match_idx), 48'(idx));
        chkb("bcast", is_bcast, bc);
        chkb("mcast", is_mcast, (len >= 10) ? a1[0] : 1'b0);
        chkb("hdr_err_clean", hdr_err, 1'b0);
        chkb("fcs_lock", fcs_ok_lock, ok);
    endtask

    initial begin
        logic [63:0] t;
        logic [47:0] a;
        logic [31:0] r;
        int          len;
        int          j;
        logic        ok;

        s00_axi_aresetn         = 1'b0;
        pkt_header_valid_strobe = 1'b0;
        byte_in_strobe          = 1'b0;
        byte_in                 = '0;
        byte_count              = '0;
        fcs_in_strobe           = 1'b0;
        fcs_ok                  = 1'b0;
        own_mac                 = '0;
        own_mac_en              = '0;
        bcast_accept            = 1'b0;
        repeat (3) tick();
        chkb("rst_fc_valid", FC_DI_valid, 1'b0);
        chkw("rst_addr1", addr1, 48'h0);
        chkb("rst_pkt_done", pkt_done, 1'b0);
        chkb("rst_hdr_err", hdr_err, 1'b0);
        chkb("rst_for_me", pkt_for_me, 1'b0);
        s00_axi_aresetn = 1'b1;
        tick();

        load_std();
        own_mac[47:0] = 48'hFFEEDDCCBBAA;
        own_mac_en    = 4'b0001;
        send_frame(64, 1'b1, 1'b0, 1'b0);
        exp_frame(64, 1'b1);
        chkw("std_fc", 48'(FC_DI), 48'h0000_0000_0108);
        chkw("std_a1", addr1, 48'hFFEEDDCCBBAA);
        chkw("std_a2", addr2, 48'h665544332211);
        chkw("std_a3", addr3, 48'hCCBBAA998877);
        chkb("std_for_me", pkt_for_me, 1'b1);
        chkw("std_idx", 48'(match_idx), 48'h0);
        chkb("std_fcs", fcs_ok_lock, 1'b1);

        own_mac[48*2 +: 48] = 48'hFFEEDDCCBBAA;
        own_mac_en = 4'b0100;
        send_frame(40, 1'b1, 1'b1, 1'b0);
        exp_frame(40, 1'b1);
        chkb("slot2_for_me", pkt_for_me, 1'b1);
        chkw("slot2_idx", 48'(match_idx), 48'h2);

        own_mac_en = 4'b0000;
        send_frame(30, 1'b1, 1'b0, 1'b0);
        chkb("nomatch_for_me", pkt_for_me, 1'b0);

        for (int i = 4; i < 10; i++) fb[i] = 8'hFF;
        bcast_accept = 1'b1;
        send_frame(24, 1'b1, 1'b0, 1'b0);
        exp_frame(24, 1'b1);
        chkb("bc_is_bcast", is_bcast, 1'b1);
        chkb("bc_is_mcast", is_mcast, 1'b1);
        chkb("bc_for_me", pkt_for_me, 1'b1);
        bcast_accept = 1'b0;
        send_frame(24, 1'b1, 1'b0, 1'b0);
        chkb("bc_rej_for_me", pkt_for_me, 1'b0);

        load_std();
        fb[4] = 8'h01;
        fb[5] = 8'h00;
        fb[6] = 8'h5E;
        send_frame(24, 1'b1, 1'b0, 1'b0);
        chkb("mc_is_mcast", is_mcast, 1'b1);
        chkb("mc_is_bcast", is_bcast, 1'b0);

        load_std();
        fb[0] = 8'hD4;
        send_frame(14, 1'b0, 1'b0, 1'b0);
        exp_frame(14, 1'b0);
        chkb("ack_fc_valid", FC_DI_valid, 1'b1);
        chkb("ack_a1_valid", addr1_valid, 1'b1);
        chkb("ack_a2_valid", addr2_valid, 1'b0);
        chkb("ack_a3_valid", addr3_valid, 1'b0);
        chkb("ack_seq_valid", seq_ctrl_valid, 1'b0);
        chkb("ack_fcs", fcs_ok_lock, 1'b0);

        load_std();
        hdr_strobe();
        for (int i = 0; i < 7; i++) send_byte(fb[i], i);
        send_byte(fb[7], 8);
        chkb("err_set", hdr_err, 1'b1);
        chkb("err_a1_valid", addr1_valid, 1'b0);
        chkb("err_fc_valid", FC_DI_valid, 1'b1);
        for (int i = 9; i < 30; i++) send_byte(fb[i], i);
        chkb("err_a1_stays", addr1_valid, 1'b0);
        send_fcs(1'b1);
        chkb("err_held", hdr_err, 1'b1);
        hdr_strobe();
        chkb("err_cleared", hdr_err, 1'b0);
        chkb("err_clr_fcv", FC_DI_valid, 1'b0);
        chkb("err_clr_lock", fcs_ok_lock, 1'b0);
        own_mac_en = 4'b0100;
        send_frame(30, 1'b1, 1'b1, 1'b0);
        exp_frame(30, 1'b1);

        hdr_strobe();
        for (int i = 0; i < 13; i++) send_byte(fb[i], i);
        #2;
        s00_axi_aresetn = 1'b0;
        #1;
        chkb("arst_a1_valid", addr1_valid, 1'b0);
        chkw("arst_addr1", addr1, 48'h0);
        chkw("arst_fc", 48'(FC_DI), 48'h0);
        chkb("arst_fc_valid", FC_DI_valid, 1'b0);
        chkb("arst_for_me", pkt_for_me, 1'b0);
        tick();
        s00_axi_aresetn = 1'b1;
        tick();
        for (int i = 0; i < 24; i++) send_byte(fb[i], i);
        chkb("nohdr_fc_valid", FC_DI_valid, 1'b0);
        chkw("nohdr_fc", 48'(FC_DI), 48'h0);
        chkw("nohdr_addr1", addr1, 48'h0);
        fcs_in_strobe = 1'b1;
        fcs_ok        = 1'b1;
        tick();
        fcs_in_strobe = 1'b0;
        chkb("idle_fcs_ignored", pkt_done, 1'b0);
        chkb("idle_lock", fcs_ok_lock, 1'b0);
        own_mac_en = 4'b0001;
        send_frame(40, 1'b1, 1'b0, 1'b0);
        exp_frame(40, 1'b1);
        chkw("post_rst_a1", addr1, 48'hFFEEDDCCBBAA);

        repeat (40) begin
            for (int k = 0; k < N; k++) begin
                t = {$urandom(), $urandom()};
                own_mac[48*k +: 48] = t[47:0];
            end
            r = $urandom();
            own_mac_en   = r[N-1:0];
            bcast_accept = r[8];
            for (int i = 0; i < 64; i++) fb[i] = 8'($urandom());
            t = {$urandom(), $urandom()};
            case ($urandom_range(3))
                0: begin
                    j = $urandom_range(N - 1);
                    a = own_mac[48*j +: 48];
                    if (r[9]) own_mac[48*((j + 1) % N) +: 48] = a;
                end
                1: a = 48'hFFFF_FFFF_FFFF;
                2: begin
                    a    = t[47:0];
                    a[0] = 1'b1;
                end
                default: a = t[47:0];
            endcase
            for (int i = 0; i < 6; i++) fb[4+i] = a[8*i +: 8];
            case ($urandom_range(3))
                0: len = 14;
                1: len = $urandom_range(23, 4);
                default: len = $urandom_range(64, 24);
            endcase
            ok = r[12];
            send_frame(len, ok, 1'b1, 1'b1);
            exp_frame(len, ok);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
